// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encodings, frame-configuration limits and clamping helpers.
package uart_rx_pkg;

    localparam int unsigned UBRR_W    = 12;
    localparam int unsigned UCSZ_W    = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned UCSZ_MIN  = 5;
    localparam int unsigned UCSZ_MAX  = 8;
    localparam int unsigned UBRR_MIN  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Frame configuration captured when a start edge is accepted
    typedef struct packed {
        logic [UBRR_W-1:0] ubrr;
        logic [UCSZ_W-1:0] ucsz;
    } rx_cfg_t;

    function automatic logic [UBRR_W-1:0] clamp_ubrr(input logic [UBRR_W-1:0] v);
        return (v < UBRR_W'(UBRR_MIN)) ? UBRR_W'(UBRR_MIN) : v;
    endfunction

    function automatic logic [UCSZ_W-1:0] clamp_ucsz(input logic [UCSZ_W-1:0] v);
        if (v < UCSZ_W'(UCSZ_MIN)) return UCSZ_W'(UCSZ_MIN);
        if (v > UCSZ_W'(UCSZ_MAX)) return UCSZ_W'(UCSZ_MAX);
        return v;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 so an idle serial line reads high.
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-edge detection, mid-bit sampling, LSB-first assembly of 5..8 data bits,
// and a one-deep receive register with valid / frame-error / overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [UBRR_W-1:0]   UBRR,
    input  logic [UCSZ_W-1:0]   UCSZ,
    input  logic                rx_en,
    input  logic                rx,
    input  logic                rd,
    output logic [DATA_W-1:0]   UDRR,
    output logic                rx_valid,
    output logic                frame_err,
    output logic                overrun
);

    logic              rx_s;
    logic              rx_s_d;
    rx_state_e         state;
    rx_cfg_t           cfg;
    rx_cfg_t           cfg_in_c;
    logic [UBRR_W-1:0] baud_cnt;
    logic [UCSZ_W-1:0] bit_cnt;
    logic [DATA_W-1:0] shift_reg;
    logic              start_edge_c;
    logic              ack_c;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        cfg_in_c      = '0;
        cfg_in_c.ubrr = clamp_ubrr(UBRR);
        cfg_in_c.ucsz = clamp_ucsz(UCSZ);
        start_edge_c  = rx_en & rx_s_d & ~rx_s;
        // Reads are ignored while disabled so the held flags stay intact
        ack_c         = rd & rx_valid & rx_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s_d    <= 1'b1;
            state     <= ST_IDLE;
            cfg       <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            UDRR      <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_s_d <= rx_s;

            if (ack_c) begin
                rx_valid  <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            if (state == ST_IDLE) begin
                if (start_edge_c) begin
                    state     <= ST_START;
                    cfg       <= cfg_in_c;
                    baud_cnt  <= (cfg_in_c.ubrr >> 1) - UBRR_W'(1);
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end
            end else if (!rx_en) begin
                state <= ST_IDLE;
            end else if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - UBRR_W'(1);
            end else begin
                baud_cnt <= cfg.ubrr - UBRR_W'(1);
                case (state)
                    ST_START: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
                        bit_cnt   <= bit_cnt + UCSZ_W'(1);
                        if (bit_cnt == cfg.ucsz - UCSZ_W'(1)) begin
                            state <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        // Short frames sit in the top bits; right-align them
                        UDRR      <= shift_reg >> (UCSZ_W'(DATA_W) - cfg.ucsz);
                        rx_valid  <= 1'b1;
                        frame_err <= ~rx_s;
                        overrun   <= ack_c ? 1'b0 : (overrun | rx_valid);
                        state     <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected results queued and checked on completion.
module tb_uart_rx;

    logic        clk;
    logic        rst;
    logic [11:0] UBRR;
    logic [3:0]  UCSZ;
    logic        rx_en;
    logic        rx;
    logic        rd;
    logic [7:0]  UDRR;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int t_valid = 0;
    logic prev_valid = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    exp_t sb[$];

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .UBRR      (UBRR),
        .UCSZ      (UCSZ),
        .rx_en     (rx_en),
        .rx        (rx),
        .rd        (rd),
        .UDRR      (UDRR),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_valid) t_valid = cyc;
        prev_valid = rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int bit_cyc);
        rx = v;
        tick(bit_cyc);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop, input int bit_cyc);
        t_start = cyc;
        drive_bit(1'b0, bit_cyc);
        for (int i = 0; i < nbits; i++) drive_bit(data[i], bit_cyc);
        drive_bit(stop, bit_cyc);
        rx = 1'b1;
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(UDRR), 32'(e.data));
            chk({tag, "_ferr"}, 32'(frame_err), 32'(e.ferr));
        end
    endtask

    task automatic pulse_rd();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; rx_en = 1'b1; rd = 1'b0;
        UBRR = 12'd4; UCSZ = 4'd8;
        tick(3);
        chk("rst_udrr", 32'(UDRR), 32'h0);
        chk("rst_valid", 32'(rx_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        rst = 1'b0;
        tick(2);

        // 8-bit frame with latency window
        t_valid = 0;
        sb.push_back('{data: 8'h55, ferr: 1'b0});
        send_frame(8'h55, 8, 1'b1, 4);
        tick(3);
        check_frame("f55");
        chk("f55_valid", 32'(rx_valid), 32'h1);
        chk("f55_ovr", 32'(overrun), 32'h0);
        checks++;
        assert ((t_valid - t_start) >= 38 && (t_valid - t_start) <= 42) else begin
            errors++;
            $error("FAIL f55_latency observed=%0d expected=38..42", t_valid - t_start);
        end
        pulse_rd();
        chk("rd_clr_valid", 32'(rx_valid), 32'h0);
        pulse_rd();
        chk("rd_idle_udrr", 32'(UDRR), 32'h55);
        chk("rd_idle_valid", 32'(rx_valid), 32'h0);

        // 5-bit frame, LSB first 1,0,1,1,0
        UCSZ = 4'd5;
        sb.push_back('{data: 8'h0D, ferr: 1'b0});
        send_frame(8'h0D, 5, 1'b1, 4);
        tick(3);
        check_frame("f0d");
        chk("f0d_upper", 32'(UDRR[7:5]), 32'h0);
        pulse_rd();

        // Low stop bit
        UCSZ = 4'd8;
        sb.push_back('{data: 8'hA3, ferr: 1'b1});
        send_frame(8'hA3, 8, 1'b0, 4);
        tick(3);
        check_frame("fa3");
        chk("fa3_valid", 32'(rx_valid), 32'h1);
        pulse_rd();
        chk("fa3_rd_valid", 32'(rx_valid), 32'h0);
        chk("fa3_rd_ferr", 32'(frame_err), 32'h0);

        // Back-to-back without read -> overrun
        send_frame(8'h11, 8, 1'b1, 4);
        send_frame(8'h22, 8, 1'b1, 4);
        sb.push_back('{data: 8'h22, ferr: 1'b0});
        tick(3);
        check_frame("b2b");
        chk("b2b_ovr", 32'(overrun), 32'h1);
        chk("b2b_valid", 32'(rx_valid), 32'h1);
        pulse_rd();
        chk("b2b_rd_ovr", 32'(overrun), 32'h0);

        // Back-to-back with rd on the completion cycle of the second frame
        send_frame(8'h11, 8, 1'b1, 4);
        fork
            send_frame(8'h22, 8, 1'b1, 4);
            begin
                repeat (40) @(posedge clk);
                #1 rd = 1'b1;
                @(posedge clk);
                #1 rd = 1'b0;
            end
        join
        sb.push_back('{data: 8'h22, ferr: 1'b0});
        check_frame("b2b_rd");
        chk("b2b_rd_ovr0", 32'(overrun), 32'h0);
        chk("b2b_rd_valid", 32'(rx_valid), 32'h1);
        pulse_rd();

        // One-cycle glitch is rejected at the start-bit sample
        UBRR = 12'd8;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        chk("glitch_valid", 32'(rx_valid), 32'h0);
        chk("glitch_ferr", 32'(frame_err), 32'h0);
        chk("glitch_ovr", 32'(overrun), 32'h0);

        // Reset in the middle of the data bits
        UBRR = 12'd4;
        drive_bit(1'b0, 4);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 4);
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        chk("mrst_udrr", 32'(UDRR), 32'h0);
        chk("mrst_valid", 32'(rx_valid), 32'h0);
        rst = 1'b0;
        tick(12);
        chk("mrst_nostart", 32'(rx_valid), 32'h0);
        sb.push_back('{data: 8'h7E, ferr: 1'b0});
        send_frame(8'h7E, 8, 1'b1, 4);
        tick(3);
        check_frame("f7e");
        chk("f7e_valid", 32'(rx_valid), 32'h1);

        // Disable mid-data aborts without touching the held result
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 4);
        drive_bit(1'b0, 4);
        rx_en = 1'b0;
        rx = 1'b1;
        tick(4);
        rx_en = 1'b1;
        tick(45);
        chk("abort_udrr", 32'(UDRR), 32'h7E);
        chk("abort_valid", 32'(rx_valid), 32'h1);
        chk("abort_ferr", 32'(frame_err), 32'h0);
        chk("abort_ovr", 32'(overrun), 32'h0);
        pulse_rd();

        // Out-of-range configuration clamps to 5 bits / 2 cycles per bit
        UCSZ = 4'd2;
        UBRR = 12'd0;
        sb.push_back('{data: 8'h15, ferr: 1'b0});
        send_frame(8'h15, 5, 1'b1, 2);
        tick(4);
        check_frame("clamp_lo");
        chk("clamp_lo_valid", 32'(rx_valid), 32'h1);
        pulse_rd();

        UCSZ = 4'd12;
        UBRR = 12'd4;
        sb.push_back('{data: 8'hA5, ferr: 1'b0});
        send_frame(8'hA5, 8, 1'b1, 4);
        tick(3);
        check_frame("clamp_hi");
        chk("clamp_hi_ovr", 32'(overrun), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: the number of flip-flops in the rx input synchronizer, minimum 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port UBRR, input, 12 bits: clock cycles per bit period.
REQ-005 SHALL have port UCSZ, input, 4 bits: data bits per frame.
REQ-006 SHALL have port rx_en, input, 1 bit: receiver enable.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port rd, input, 1 bit: one-cycle pulse that acknowledges UDRR and clears the flags.
REQ-009 SHALL have port UDRR, output, 8 bits: last received data, right-aligned, with unused upper bits 0.
REQ-010 SHALL have port rx_valid, output, 1 bit: unread data is present in UDRR.
REQ-011 SHALL have port frame_err, output, 1 bit: the stop bit of the frame in UDRR was sampled low.
REQ-012 SHALL have port overrun, output, 1 bit: a frame completed while rx_valid was already set.

Function
REQ-013 SHALL synchronize rx through SYNC_STAGES flops (rx_s) before any use.
REQ-014 SHALL implement the states IDLE, START, DATA and STOP.
REQ-015 On leaving IDLE, SHALL latch the frame configuration:
- UBRR values below 2 SHALL be treated as 2.
- UCSZ values below 5 SHALL be treated as 5, and values above 8 as 8.
- Input changes mid-frame SHALL have no effect.
REQ-016 IDLE -> START SHALL occur when rx_en=1 and a 1->0 transition of rx_s is seen; baud_cnt SHALL load (UBRR>>1)-1.
REQ-017 baud_cnt SHALL decrement each cycle; each "sample" SHALL occur in the cycle where baud_cnt==0, after which baud_cnt reloads UBRR-1.
REQ-018 In START, at the sample:
- rx_s==0 SHALL go to DATA with bit_cnt=0.
- rx_s==1 (glitch) SHALL return to IDLE with no flag change.
REQ-019 In DATA, each sample SHALL shift rx_s in LSB first; after the UCSZ-th sample the FSM SHALL go to STOP.
REQ-020 In STOP, at the sample, the block SHALL in the same cycle:
- write UDRR;
- set rx_valid;
- set frame_err to the inverse of rx_s;
- go to IDLE (this permits back-to-back frames).
REQ-021 If a frame completes while rx_valid=1 and rd=0, SHALL overwrite UDRR and set overrun; overrun is sticky until rd.
REQ-022 rd SHALL clear rx_valid, frame_err and overrun in the next cycle.
REQ-023 rd coincident with frame completion:
- new data and frame_err SHALL be loaded;
- rx_valid SHALL remain 1;
- overrun SHALL be 0.
REQ-024 rd while rx_valid=0 SHALL have no effect.
REQ-025 rx_en=0 in any non-IDLE state SHALL abort to IDLE next cycle with no UDRR or flag change; flags and UDRR SHALL be held while disabled.
REQ-026 UDRR, rx_valid, frame_err and overrun SHALL be registered outputs.

Reset
REQ-027 With rst=1 at a clk edge:
- the state SHALL go to IDLE;
- baud_cnt, bit_cnt, the shift register, UDRR, rx_valid, frame_err and overrun SHALL be 0;
- the synchronizer flops SHALL be 1 (line idle).
REQ-028 Reset asserted mid-frame SHALL discard the partial frame, and no spurious start SHALL be detected on the following cycle.

Structure
REQ-029 State encodings and the UCSZ_MIN=5, UCSZ_MAX=8 and UBRR_MIN=2 constants SHALL live in the shared UART definitions header used by the other UART blocks.
REQ-030 The synchronizer SHALL be a sub-module named uart_sync (parameterized depth, reset to 1); the remaining logic SHALL stay flat in uart_rx.

Verification
REQ-031 UBRR=4, UCSZ=8: drive frame 0x55 with a valid stop bit -> UDRR=0x55, rx_valid=1, frame_err=0, asserted 38-42 cycles after the rx falling edge.
REQ-032 UBRR=4, UCSZ=5: drive data bits 10110 (LSB first) -> UDRR=0x0D, upper 3 bits 0.
REQ-033 UBRR=4: drive 0xA3 with a low stop bit -> UDRR=0xA3, frame_err=1; rd pulse -> rx_valid=0 and frame_err=0 next cycle.
REQ-034 Two back-to-back frames 0x11 then 0x22 with no rd -> UDRR=0x22, overrun=1; repeat with rd on the completion cycle of 0x22 -> overrun=0, rx_valid=1.
REQ-035 A 1-cycle low glitch on rx with UBRR=8 -> returns to IDLE, no flags; rst asserted mid-DATA -> all outputs 0, and the next clean frame 0x7E is received correctly.
REQ-036 rx_en dropped mid-DATA -> abort with the previous UDRR and flags unchanged; UCSZ=2 and UBRR=0 -> behave as 5 bits and 2 cycles per bit.
